// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the ROM combinationally and queues
// {pc, instruction} into a 2-entry skid buffer feeding decode; handles redirects and HALT.
module fetch_unit #(
    parameter int                     PC_W      = 6,
    parameter int                     INSTR_W   = 32,
    parameter logic [PC_W-1:0]        RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]     HALT_WORD = 32'h0000_0031
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [1:0]      count;
    entry_t          head;
    entry_t          tail;
    entry_t          fetched;
    logic            pop;
    logic            push;
    logic            hit_halt;

    assign fetched  = {pc_q, instruction};
    assign hit_halt = (instruction == HALT_WORD);
    assign if_valid = (count != 2'd0);
    assign pop      = if_valid & id_ready;
    // A pop frees a slot in the same cycle, so a full buffer still streams 1/cycle.
    assign push     = (state == RUN) & ~redirect & ((count < 2'd2) | pop);

    assign pc       = pc_q;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

    // Control: PC sequencing and RUN/HALTED. Redirect wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
            pc_q   <= RESET_PC;
        end else if (redirect) begin
            state  <= RUN;
            halted <= 1'b0;
            pc_q   <= redirect_pc;
        end else if (push) begin
            if (hit_halt) begin
                // PC parks on the HALT address so a later redirect is the only way out.
                state  <= HALTED;
                halted <= 1'b1;
            end else begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

    // Skid buffer: head is what decode sees, tail only holds data when count==2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= fetched;
                    else               tail <= fetched;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= fetched;
                    end else begin
                        head <= fetched;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
